risc16_uart_tx: RTL
===================

# risc16_uart_tx

Memory-mapped UART transmitter that sits on the risc16f core's data bus, downstream of its EX stage. It decodes the core's `daddr`, `ddout`, `dwe` and `doe`, and buffers written bytes in a small FIFO. It serialises each byte as an 8N1 frame on `txd` with a programmable bit period. Read data is returned combinationally in the same cycle, because the core samples `ddin` in the cycle it asserts `doe`.

## Interface
- `BASE_ADDR`, default 16'hFF00: base byte address of the 8-byte register window. Bits [2:0] must be 0.
- `FIFO_DEPTH`, default 8: number of TX FIFO entries. Must be a power of 2, from 2 to 8.
- `DIV_RESET`, default 16'd868: reset value of the divisor register.
- `clk` input 1: clock, clk.
- `rst` input 1: reset rst, synchronous, active-high.
- `daddr` input 16: byte address from the core.
- `wdata` input 16: write data, connected to the core's `ddout`.
- `dwe` input 1: write strobe.
- `doe` input 1: read strobe.
- `rdata` output 16: read data toward the core's `ddin` mux. Combinational.
- `hit` output 1: high when `(doe|dwe)` is asserted and the address is inside the window. Combinational.
- `txd` output 1: serial line. Idles high.

## Operation
- Address decode:
  - Window hit when `daddr[15:3] == BASE_ADDR[15:3]`.
  - `daddr[2:1]` selects the register; `daddr[0]` is ignored.
- Register map:
  - Offset 0, TXDATA: a write pushes `wdata[7:0]` into the FIFO. Reads return 0.
  - Offset 2, STATUS: read-only fields, except bit3.
    - bit0 = full, bit1 = empty, bit2 = busy (FSM not IDLE), bit3 = overflow (sticky).
    - bits[7:4] = FIFO count. All other bits read 0.
    - Writing with `wdata[3]=1` clears overflow. Writes to other bits are ignored.
  - Offset 4, DIV: read/write bit period in clocks. A value of 0 is treated as 1.
  - Offset 6: reserved. Reads return 0; writes are ignored.
- `rdata`:
  - Equals the selected register when `doe` and the window hit.
  - Otherwise `rdata` = 0.
- FIFO push:
  - Happens on the clk edge where `dwe` is high and the address is TXDATA.
  - If the FIFO is full at that edge, the byte is dropped and overflow is set. This holds even if a pop occurs on the same edge.
  - Push and pop on the same edge with the FIFO neither full nor empty: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - `txd`=1.
    - If the FIFO is not empty, pop the head into the shift register, load the bit counter with DIV-1, and go to START.
  - START:
    - `txd`=0 for DIV clocks, then load bit index 0 and go to DATA.
  - DATA:
    - `txd`=`shift[0]` for DIV clocks per bit, LSB first.
    - Shift right after each bit.
    - After bit 7, go to STOP.
  - STOP:
    - `txd`=1 for DIV clocks, then go to IDLE.
- The bit counter reloads from the current DIV register at every bit boundary. A DIV write during a frame therefore takes effect at the next bit boundary; the bit in progress keeps its length.
- `txd` is driven from a register, so there is no combinational glitch.

## Timing
- Reset values:
  - `txd`=1, FSM state IDLE, FIFO empty (count 0), overflow=0, DIV=`DIV_RESET`.
  - `rdata` and `hit` are combinational, so they are 0 unless a strobe is asserted.
- Reset asserted mid-frame: on the next edge the frame is aborted, `txd` returns to 1, and the FIFO contents are discarded.
- Push-to-start latency into an empty, idle block:
  - The push lands at edge k.
  - The FSM leaves IDLE at edge k+1.
  - `txd` falls after edge k+1.
- Frame length is exactly 10×DIV clocks.
- Back-to-back frames are separated by one IDLE clock with `txd`=1. Frame period is 10×DIV+1.
- STATUS reflects register state before the current edge. A read in the same cycle as a TXDATA write shows the pre-write count.
- busy deasserts on the edge that returns the FSM to IDLE.

## Test plan
- Reset, then read STATUS, DIV and offset 6 -> STATUS=0x0002, DIV=`DIV_RESET`, offset 6 reads 0x0000, `txd`=1.
- Write DIV=4, then TXDATA=0x00A5 -> `txd` low for 4 clocks, then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then high for 4 clocks; busy is 1 for 40 clocks.
- With DIV=100, write 9 bytes back-to-back -> after the 8th, STATUS shows full=1 and count=8; after the 9th, overflow=1 and the 9th byte never appears on `txd`. A STATUS write of 0x0008 then clears overflow.
- With DIV=4, write 0x01 and 0x02 -> two frames separated by exactly one idle clock; after both frames, empty=1 and busy=0.
- Write DIV=8 during bit 3 of a frame running at DIV=4 -> bit 3 lasts 4 clocks; bits 4–7 and the stop bit last 8 clocks each.
- Assert `rst` during bit 5 -> `txd`=1 on the next clock, STATUS reads 0x0002, and no frame restarts.

Source files
------------

// File: rtl/risc16_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the risc16f data bus.
// Bytes written to TXDATA queue in a small FIFO and go out on txd at DIV clocks per bit.
module risc16_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] wdata,
  input  logic        dwe,
  input  logic        doe,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        txd
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q,   state_d;
  logic [7:0]       fifo_q     [FIFO_DEPTH];
  logic [7:0]       fifo_d     [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [3:0]       count_q,   count_d;
  logic             ovf_q,     ovf_d;
  logic [15:0]      div_q,     div_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             txd_q,     txd_d;

  logic        win;
  logic [1:0]  sel;
  logic        full;
  logic        empty;
  logic        busy;
  logic [15:0] reload;
  logic        push_req;
  logic        push;
  logic        pop;
  logic [15:0] status;
  logic        unused_addr_lsb;

  // Bus decode: byte lane bit is irrelevant for 16-bit registers.
  assign win             = (daddr[15:3] == BASE_ADDR[15:3]);
  assign sel             = daddr[2:1];
  assign unused_addr_lsb = daddr[0];
  assign hit             = (doe | dwe) & win;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == 4'd0);
  assign busy   = (state_q != S_IDLE);
  assign reload = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
  assign status = {8'h00, count_q, ovf_q, busy, empty, full};

  assign push_req = dwe & win & (sel == REG_TXDATA);
  assign push     = push_req & ~full;
  assign pop      = (state_q == S_IDLE) & ~empty;

  assign txd = txd_q;

  always_comb begin
    rdata = 16'h0000;
    if (doe && win) begin
      case (sel)
        REG_STATUS: rdata = status;
        REG_DIV:    rdata = div_q;
        default:    rdata = 16'h0000;
      endcase
    end
  end

  // FIFO and register file next state; a full FIFO drops the byte even if the FSM pops this edge.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push) begin
      fifo_d[wr_ptr_q] = wdata[7:0];
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (dwe && win && (sel == REG_STATUS) && wdata[3]) begin
      ovf_d = 1'b0;
    end
    if (dwe && win && (sel == REG_DIV)) begin
      div_d = wdata;
    end
  end

  // Serialiser: the bit counter reloads from the live DIV at every bit boundary.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d   = fifo_q[rd_ptr_q];
          bit_cnt_d = reload;
          txd_d     = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_cnt_q == 16'd0) begin
          bit_idx_d = 3'd0;
          bit_cnt_d = reload;
          txd_d     = shift_q[0];
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = reload;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == 16'd0) begin
          txd_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    fifo_q  <= fifo_d;
    shift_q <= shift_d;
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 4'd0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

endmodule
